doorlock_ctrl_p: RTL and testbench
==================================

Name: doorlock_ctrl_p

Overview:
- Parametrised next-generation door-lock core, self-contained: key encoder, entry buffer, stored password, comparators and control FSM in one block.
- Adds the following over the current lock:
  - variable-length PINs
  - user password change gated by an open door
  - failed-attempt lockout with timeout
  - timed auto-relock
- Sits between the debounced keypad and the lock actuator.

Parameters:
- NUM_KEYS, 10: digit buttons; key i encodes digit i.
- MAX_LEN, 8: maximum PIN digits (4 bits each).
- MIN_LEN, 4: minimum digits accepted when setting a new PIN.
- DEFAULT_PW, 32'h0000_1234: reset PIN, right-aligned, last digit in [3:0].
- DEFAULT_LEN, 4: reset PIN length.
- MASTER_PW, 32'h0000_2718: fixed master PIN, same alignment.
- MASTER_LEN, 4: master PIN length.
- OPEN_CYCLES, 8: cycles the lock stays open before auto-relock.
- MAX_FAILS, 3: consecutive failures that trigger lockout.
- LOCKOUT_CYCLES, 16: lockout duration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digit_buttons  in  NUM_KEYS  one-cycle press pulses, already debounced.
- confirm_button  in  1  one-cycle pulse.
- change_button  in  1  one-cycle pulse; request PIN change.
- shuffle_button  in  1  one-cycle pulse; used only with SHUFFLE_EN.
- locked  out  1  1 = door locked.
- lockout  out  1  1 = LOCKOUT state.
- set_err  out  1  one-cycle pulse: new PIN rejected.
- digit_count  out  $clog2(MAX_LEN+1)  digits currently buffered.
- fail_count  out  $clog2(MAX_FAILS+1)  consecutive failures.

Behaviour:
- Reset values: state IDLE, locked=1, lockout=0, set_err=0, digit_count=0, fail_count=0, stored PIN=DEFAULT_PW/DEFAULT_LEN, all timers 0.
- rst asserted mid-operation aborts everything at the next edge to the values above, including any PIN changed since the last reset.
- Digit acceptance:
  - Accepted only when exactly one digit_buttons bit is set; zero or multiple bits are ignored.
  - Accepted digit is shifted into the buffer LSB side; digit_count increments.
  - Accepted only in IDLE and SET_NEW.
  - At digit_count==MAX_LEN further digits are dropped; buffer and count are unchanged.
- Priority in a cycle: confirm_button > change_button > digit; lower-priority events in the same cycle are discarded.
- States:
  - IDLE: locked=1.
    - confirm → CHECK.
    - change_button ignored.
  - CHECK, one cycle.
    - Match if digit_count==stored length and the low digits equal the stored PIN, or if digit_count==MASTER_LEN and the low digits equal MASTER_PW. Leading buffer contents above digit_count are don't-care.
    - On match: → OPEN, fail_count=0.
    - Else: fail_count+1; if it reaches MAX_FAILS → LOCKOUT, otherwise → IDLE.
    - Buffer is cleared in CHECK.
    - confirm→locked falling: 2 clk edges.
  - OPEN: locked=0; timer counts OPEN_CYCLES.
    - At expiry → IDLE, locked=1.
    - confirm → IDLE immediately.
    - change_button → SET_NEW; buffer is cleared and the door stays open.
  - SET_NEW: locked=0; digits accepted; timer frozen.
    - confirm with digit_count ≥ MIN_LEN: store buffer and length → IDLE, locked=1.
    - confirm with digit_count < MIN_LEN: set_err pulses 1 cycle, PIN unchanged → IDLE.
    - change_button: abort → IDLE, PIN unchanged.
  - LOCKOUT: lockout=1, locked=1; all buttons ignored.
    - After LOCKOUT_CYCLES → IDLE, fail_count=0.
    - Master PIN cannot bypass lockout.
- A zero-length confirm in IDLE is a failure unless the stored length is 0; a stored length of 0 is unreachable.

Optional Feature:
- Macro SHUFFLE_EN.
- When defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) free-runs.
  - In IDLE, shuffle_button latches offset = LFSR mod NUM_KEYS.
  - Encoded digit = (key index + offset) mod NUM_KEYS.
  - Offset resets to 0, and returns to 0 on entering OPEN.
- When not defined: offset is constant 0 and shuffle_button is ignored.

Test Plan:
- Reset; press 1,2,3,4, confirm → locked=0 exactly 2 edges after confirm, 1 again after 8 open cycles; fail_count=0.
- Press 9,9,9,9, confirm ×3 → fail_count 1,2, then lockout=1 for 16 cycles; 1,2,3,4 + confirm during lockout has no effect; then IDLE with fail_count=0.
- Open with 1234, change_button, enter 5,6,7,8,0, confirm → locked=1; 1234 now fails; 56780 opens.
- In SET_NEW enter 4,2, confirm → set_err one-cycle pulse, PIN still 1234.
- Master 2,7,1,8 opens the lock; enter 9 digits → digit_count saturates at 8; digit and confirm in the same cycle → digit dropped.
- With SHUFFLE_EN: shuffle yields offset k; pressing keys (1-k),(2-k),(3-k),(4-k) mod 10 + confirm opens; rst mid-OPEN → locked=1 next edge and offset 0.

Source files
------------

// File: rtl/doorlock_ctrl_p.sv
// Parametrised door-lock core: key encoder, PIN entry buffer, stored PIN, match logic and control FSM.
// Optional keypad scrambling is compiled in with `define SHUFFLE_EN.
module doorlock_ctrl_p #(
  parameter int NUM_KEYS       = 10,
  parameter int MAX_LEN        = 8,
  parameter int MIN_LEN        = 4,
  parameter logic [4*MAX_LEN-1:0] DEFAULT_PW = 'h0000_1234,
  parameter int DEFAULT_LEN    = 4,
  parameter logic [4*MAX_LEN-1:0] MASTER_PW  = 'h0000_2718,
  parameter int MASTER_LEN     = 4,
  parameter int OPEN_CYCLES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_KEYS-1:0]          digit_buttons,
  input  logic                         confirm_button,
  input  logic                         change_button,
  input  logic                         shuffle_button,
  output logic                         locked,
  output logic                         lockout,
  output logic                         set_err,
  output logic [$clog2(MAX_LEN+1)-1:0] digit_count,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int DW   = 4 * MAX_LEN;
  localparam int CW   = $clog2(MAX_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int KW   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, CHECK, OPEN, SET_NEW, LOCKOUT} state_t;

  state_t          state, next_state;
  logic [DW-1:0]   entry_buf, stored_pw, mask;
  logic [CW-1:0]   stored_len;
  logic [TW-1:0]   timer;
  logic [KW-1:0]   offset;
  logic [3:0]      key_idx, key_digit;
  logic [4:0]      key_sum;
  logic            key_valid, pin_match;
  logic            accept_digit, clr_buf, store_pin, set_err_nxt;
  logic            clr_fail, inc_fail, timer_run, enter_open;
  logic [FW-1:0]   fail_next;

  // Key encoder: only a single pressed key counts, rotated by the shuffle offset.
  always_comb begin
    key_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (digit_buttons[i]) key_idx = 4'(i);
    key_valid = $onehot(digit_buttons);
    key_sum   = {1'b0, key_idx} + 5'(offset);
    key_digit = (key_sum >= 5'(NUM_KEYS)) ? 4'(key_sum - 5'(NUM_KEYS)) : key_sum[3:0];
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[4*i +: 4] = (i < int'(digit_count)) ? 4'hF : 4'h0;
    pin_match = ((digit_count == stored_len) && (((entry_buf ^ stored_pw) & mask) == '0)) ||
                ((digit_count == CW'(MASTER_LEN)) && (((entry_buf ^ MASTER_PW) & mask) == '0));
    fail_next = fail_count + FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    accept_digit = 1'b0;
    clr_buf      = 1'b0;
    store_pin    = 1'b0;
    set_err_nxt  = 1'b0;
    clr_fail     = 1'b0;
    inc_fail     = 1'b0;
    timer_run    = 1'b0;
    enter_open   = 1'b0;
    case (state)
      IDLE: begin
        if (confirm_button) next_state = CHECK;
        else if (!change_button && key_valid && digit_count < CW'(MAX_LEN)) accept_digit = 1'b1;
      end
      CHECK: begin
        clr_buf = 1'b1;
        if (pin_match) begin
          next_state = OPEN;
          clr_fail   = 1'b1;
          enter_open = 1'b1;
        end else begin
          inc_fail   = 1'b1;
          next_state = (fail_next == FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
        end
      end
      OPEN: begin
        timer_run = 1'b1;
        if (confirm_button) next_state = IDLE;
        else if (change_button) begin
          next_state = SET_NEW;
          clr_buf    = 1'b1;
        end else if (timer == TW'(OPEN_CYCLES - 1)) next_state = IDLE;
      end
      SET_NEW: begin
        if (confirm_button) begin
          next_state = IDLE;
          clr_buf    = 1'b1;
          if (digit_count >= CW'(MIN_LEN)) store_pin   = 1'b1;
          else                             set_err_nxt = 1'b1;
        end else if (change_button) begin
          next_state = IDLE;
          clr_buf    = 1'b1;
        end else if (key_valid && digit_count < CW'(MAX_LEN)) accept_digit = 1'b1;
      end
      LOCKOUT: begin
        timer_run = 1'b1;
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          next_state = IDLE;
          clr_fail   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Timer restarts from zero whenever the FSM passes through IDLE or CHECK and holds in SET_NEW.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_buf   <= '0;
      digit_count <= '0;
      stored_pw   <= DEFAULT_PW;
      stored_len  <= CW'(DEFAULT_LEN);
      fail_count  <= '0;
      timer       <= '0;
      set_err     <= 1'b0;
    end else begin
      set_err <= set_err_nxt;
      if (store_pin) begin
        stored_pw  <= entry_buf;
        stored_len <= digit_count;
      end
      if (clr_buf) begin
        entry_buf   <= '0;
        digit_count <= '0;
      end else if (accept_digit) begin
        entry_buf   <= {entry_buf[DW-5:0], key_digit};
        digit_count <= digit_count + CW'(1);
      end
      if (clr_fail)      fail_count <= '0;
      else if (inc_fail) fail_count <= fail_next;
      if (timer_run)                          timer <= timer + TW'(1);
      else if (state == IDLE || state == CHECK) timer <= '0;
    end
  end

`ifdef SHUFFLE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= 16'hACE1;
      offset <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (enter_open)                           offset <= '0;
      else if (state == IDLE && shuffle_button) offset <= KW'(lfsr % 16'(NUM_KEYS));
    end
  end
`else
  logic unused_shuffle;
  assign offset         = '0;
  assign unused_shuffle = shuffle_button;
`endif

  assign locked  = !(state == OPEN || state == SET_NEW);
  assign lockout = (state == LOCKOUT);

endmodule

// File: tb/tb_doorlock_ctrl_p.sv
// Self-checking bench for doorlock_ctrl_p: expectations are queued before each stimulus cycle
// and compared just after the clock edge that should produce them.
module tb_doorlock_ctrl_p;

  localparam int MAX_FAILS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] digit_buttons = '0;
  logic       confirm_button = 1'b0;
  logic       change_button = 1'b0;
  logic       shuffle_button = 1'b0;
  logic       locked, lockout, set_err;
  logic [3:0] digit_count;
  logic [1:0] fail_count;

  doorlock_ctrl_p dut (
    .clk(clk), .rst(rst),
    .digit_buttons(digit_buttons), .confirm_button(confirm_button),
    .change_button(change_button), .shuffle_button(shuffle_button),
    .locked(locked), .lockout(lockout), .set_err(set_err),
    .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  typedef enum int {SEL_LOCKED, SEL_LOCKOUT, SEL_SETERR, SEL_COUNT, SEL_FAIL} sel_t;
  typedef struct {
    string tag;
    sel_t  sel;
    int    value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

`ifdef SHUFFLE_EN
  logic [15:0] model_lfsr;
  logic [15:0] pre_edge_lfsr = '0;
  always @(posedge clk) begin
    if (rst) model_lfsr <= 16'hACE1;
    else     model_lfsr <= {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end
`endif

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int observe(input sel_t s);
    case (s)
      SEL_LOCKED:  return int'(locked);
      SEL_LOCKOUT: return int'(lockout);
      SEL_SETERR:  return int'(set_err);
      SEL_COUNT:   return int'(digit_count);
      default:     return int'(fail_count);
    endcase
  endfunction

  task automatic expectOutput(input string tag, input sel_t sel, input int value);
    exp_t e;
    e.tag = tag; e.sel = sel; e.value = value;
    sb.push_back(e);
  endtask

  // One clock of stimulus; queued expectations describe the outputs right after this edge.
  task automatic applyStimulus(input logic [9:0] keys, input logic conf, input logic chg, input logic shf);
    exp_t e;
    @(negedge clk);
    digit_buttons = keys; confirm_button = conf; change_button = chg; shuffle_button = shf;
`ifdef SHUFFLE_EN
    pre_edge_lfsr = model_lfsr;
`endif
    @(posedge clk);
    #1;
    digit_buttons = '0; confirm_button = 1'b0; change_button = 1'b0; shuffle_button = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sel), e.value);
    end
  endtask

  task automatic idleCycle();
    applyStimulus('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressKey(input int k);
    applyStimulus(10'b1 << k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    idleCycle();
    expectOutput("rst_locked", SEL_LOCKED, 1);
    expectOutput("rst_lockout", SEL_LOCKOUT, 0);
    expectOutput("rst_seterr", SEL_SETERR, 0);
    expectOutput("rst_count", SEL_COUNT, 0);
    expectOutput("rst_fail", SEL_FAIL, 0);
    idleCycle();
    rst = 1'b0;
  endtask

  // Enter a PIN (most significant digit first), confirm and check the result two edges later.
  task automatic tryPin(input logic [31:0] pin, input int len, input bit opens, input int exp_fail, input string tag);
    for (int i = len - 1; i >= 0; i--) begin
      expectOutput({tag, "_cnt"}, SEL_COUNT, (len - i > 8) ? 8 : len - i);
      pressKey(int'(pin[4*i +: 4]));
    end
    expectOutput({tag, "_check_locked"}, SEL_LOCKED, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    expectOutput({tag, "_locked"}, SEL_LOCKED, opens ? 0 : 1);
    expectOutput({tag, "_fail"}, SEL_FAIL, exp_fail);
    expectOutput({tag, "_lockout"}, SEL_LOCKOUT, (exp_fail == MAX_FAILS) ? 1 : 0);
    expectOutput({tag, "_cnt_clr"}, SEL_COUNT, 0);
    idleCycle();
  endtask

  initial begin
    resetDut();

    // Correct PIN, auto-relock after eight open cycles
    tryPin(32'h1234, 4, 1'b1, 0, "open1234");
    for (int i = 0; i < 7; i++) begin
      expectOutput("still_open", SEL_LOCKED, 0);
      idleCycle();
    end
    expectOutput("auto_relock", SEL_LOCKED, 1);
    idleCycle();

    // Three failures, then lockout ignores everything for sixteen cycles
    tryPin(32'h9999, 4, 1'b0, 1, "bad1");
    tryPin(32'h9999, 4, 1'b0, 2, "bad2");
    tryPin(32'h9999, 4, 1'b0, 3, "bad3");
    for (int j = 1; j <= 15; j++) begin
      expectOutput("lockout_held", SEL_LOCKOUT, 1);
      expectOutput("lockout_count", SEL_COUNT, 0);
      expectOutput("lockout_locked", SEL_LOCKED, 1);
      if (j <= 4)       pressKey(j);
      else if (j == 5)  applyStimulus('0, 1'b1, 1'b0, 1'b0);
      else if (j == 6)  applyStimulus('0, 1'b0, 1'b1, 1'b0);
      else              idleCycle();
    end
    expectOutput("lockout_end", SEL_LOCKOUT, 0);
    expectOutput("lockout_fail_clr", SEL_FAIL, 0);
    idleCycle();

    // PIN change to 56780 with the timer frozen in SET_NEW
    tryPin(32'h1234, 4, 1'b1, 0, "open_for_change");
    expectOutput("setnew_open", SEL_LOCKED, 0);
    expectOutput("setnew_cnt", SEL_COUNT, 0);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expectOutput("setnew_digit_cnt", SEL_COUNT, i + 1);
      pressKey((i == 4) ? 0 : i + 5);
    end
    for (int i = 0; i < 10; i++) begin
      expectOutput("setnew_timer_frozen", SEL_LOCKED, 0);
      idleCycle();
    end
    expectOutput("setnew_store_locked", SEL_LOCKED, 1);
    expectOutput("setnew_store_seterr", SEL_SETERR, 0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    tryPin(32'h1234, 4, 1'b0, 1, "old_pin");
    tryPin(32'h56780, 5, 1'b1, 0, "new_pin");
    expectOutput("confirm_closes", SEL_LOCKED, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);

    // Reset restores the default PIN; too-short new PIN is rejected
    resetDut();
    tryPin(32'h1234, 4, 1'b1, 0, "default_back");
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    pressKey(4);
    pressKey(2);
    expectOutput("short_seterr", SEL_SETERR, 1);
    expectOutput("short_locked", SEL_LOCKED, 1);
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    expectOutput("short_seterr_pulse", SEL_SETERR, 0);
    idleCycle();
    tryPin(32'h1234, 4, 1'b1, 0, "after_short");
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pressKey(9);
    expectOutput("abort_locked", SEL_LOCKED, 1);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    tryPin(32'h1234, 4, 1'b1, 0, "after_abort");
    applyStimulus('0, 1'b1, 1'b0, 1'b0);

    // Master PIN, saturation at eight digits, confirm beats digit, invalid key patterns
    tryPin(32'h2718, 4, 1'b1, 0, "master");
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      expectOutput("sat_cnt", SEL_COUNT, (i > 8) ? 8 : i);
      pressKey(i % 10);
    end
    applyStimulus('0, 1'b1, 1'b0, 1'b0);
    expectOutput("sat_fail", SEL_FAIL, 1);
    idleCycle();
    pressKey(1);
    pressKey(2);
    pressKey(3);
    expectOutput("confirm_drops_digit", SEL_COUNT, 3);
    applyStimulus(10'b1 << 4, 1'b1, 1'b0, 1'b0);
    expectOutput("short_entry_fail", SEL_FAIL, 2);
    expectOutput("short_entry_locked", SEL_LOCKED, 1);
    idleCycle();
    expectOutput("multi_key_ignored", SEL_COUNT, 0);
    applyStimulus(10'b00_0000_0011, 1'b0, 1'b0, 1'b0);
    expectOutput("change_drops_digit", SEL_COUNT, 0);
    applyStimulus(10'b00_0000_0010, 1'b0, 1'b1, 1'b0);
    resetDut();

`ifdef SHUFFLE_EN
    begin
      int k;
      applyStimulus('0, 1'b0, 1'b0, 1'b1);
      k = int'(pre_edge_lfsr % 16'd10);
      for (int d = 1; d <= 4; d++) begin
        expectOutput("shuffle_cnt", SEL_COUNT, d);
        pressKey((d - k + 10) % 10);
      end
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
      expectOutput("shuffle_open", SEL_LOCKED, 0);
      idleCycle();
      rst = 1'b1;
      expectOutput("rst_mid_open", SEL_LOCKED, 1);
      idleCycle();
      rst = 1'b0;
      tryPin(32'h1234, 4, 1'b1, 0, "offset_zero");
      applyStimulus('0, 1'b1, 1'b0, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
